// File: rtl/alu_pipe_if.sv
// Operation/result bus for alu_pipe.
// Request side: in_valid/in_ready with operands and opcode.
// Response side: out_valid/out_ready with the result and the four flags.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             carryout;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, y, carryout, zero, negative, overflow
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, y, carryout, zero, negative, overflow
   );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 holds the accepted operation; execute is combinational from S1;
// S2 holds the result and flags and drives the outputs directly.
// cf is the carry of the most recent op to move S1->S2, consumed by ADC.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_ADC = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_y;
   logic             s2_c;
   logic             s2_z;
   logic             s2_n;
   logic             s2_v;

   logic             cf;

   logic             s1_advance;
   logic             s1_load;

   logic [WIDTH:0]   add_res;
   logic [WIDTH:0]   sub_res;
   logic             adc_cin;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] ex_y;
   logic             ex_c;
   logic             ex_v;

   assign s1_advance   = s1_valid && (!s2_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s1_advance;
   assign s1_load      = bus.in_valid && bus.in_ready;

   assign bus.out_valid = s2_valid;
   assign bus.y         = s2_y;
   assign bus.carryout  = s2_c;
   assign bus.zero      = s2_z;
   assign bus.negative  = s2_n;
   assign bus.overflow  = s2_v;

   // Execute: WIDTH+1-bit add/sub so the MSB is carry (or borrow for SUB).
   assign adc_cin = (s1_op == OP_ADC) && cf;
   assign add_res = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, adc_cin};
   assign sub_res = {1'b0, s1_a} - {1'b0, s1_b};
   assign shamt   = s1_b[SW-1:0];

   // Select result, carry and signed overflow for the op sitting in S1.
   always_comb begin
      ex_y = '0;
      ex_c = 1'b0;
      ex_v = 1'b0;
      case (s1_op)
         OP_ADD, OP_ADC: begin
            ex_y = add_res[WIDTH-1:0];
            ex_c = add_res[WIDTH];
            ex_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                   (add_res[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            ex_y = sub_res[WIDTH-1:0];
            ex_c = sub_res[WIDTH];
            ex_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                   (sub_res[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_AND:  ex_y = s1_a & s1_b;
         OP_OR:   ex_y = s1_a | s1_b;
         OP_XOR:  ex_y = s1_a ^ s1_b;
         OP_SLL:  ex_y = s1_a << shamt;
         OP_SRL:  ex_y = s1_a >> shamt;
         default: ex_y = '0;
      endcase
   end

   // S1: capture operands on accept; empty when it advances with no refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_op    <= bus.opcode;
         end else if (s1_advance) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // S2 and cf: load on S1 advance, drain on handshake, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         s2_c     <= 1'b0;
         s2_z     <= 1'b0;
         s2_n     <= 1'b0;
         s2_v     <= 1'b0;
         cf       <= 1'b0;
      end else begin
         if (s1_advance) begin
            s2_valid <= 1'b1;
            s2_y     <= ex_y;
            s2_c     <= ex_c;
            s2_z     <= (ex_y == '0);
            s2_n     <= ex_y[WIDTH-1];
            s2_v     <= ex_v;
            cf       <= ex_c;
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8 with a queue-based scoreboard.
// The driver pushes the hand-computed result of every op it presents;
// the monitor pops and compares on each output handshake.
module tb_alu_pipe;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // expected = {y, carryout, zero, negative, overflow}
   logic [W+3:0] exp_q[$];

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W+3:0] res(input logic [W-1:0] y, input logic c,
                                        input logic z, input logic n, input logic v);
      return {y, c, z, n, v};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake occurs at the next rising edge when both are high here.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {bus.y, bus.carryout, bus.zero, bus.negative, bus.overflow}, 64'hDEAD);
         end else begin
            check("result", {bus.y, bus.carryout, bus.zero, bus.negative, bus.overflow}, exp_q.pop_front());
         end
      end
   end

   task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+3:0] e);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      bus.a        = a;
      bus.b        = b;
      exp_q.push_back(e);
   endtask

   task automatic wait_accept(input string name);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #2;
         n++;
      end
      if (!acc) check(name, 64'd0, 64'd1);
   endtask

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] e);
      drive(op, a, b, e);
      wait_accept("accept_timeout");
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.opcode    = '0;
      rst_n         = 1'b0;
      repeat (3) step();

      check("reset_out_valid", bus.out_valid, 0);
      check("reset_outputs", {bus.y, bus.carryout, bus.zero, bus.negative, bus.overflow}, 0);
      rst_n = 1'b1;
      step();
      check("reset_in_ready", bus.in_ready, 1);

      // ADD latency: accept at edge N, out_valid after edge N+1
      send(3'd0, 8'd200, 8'd100, res(8'd44, 1, 0, 0, 0));
      idle();
      check("latency_n", bus.out_valid, 0);
      step();
      check("latency_n1", bus.out_valid, 1);
      repeat (2) step();

      // back-to-back SUBs, then ADC consuming the borrow of 3-5
      send(3'd1, 8'd5, 8'd5, res(8'd0, 0, 1, 0, 0));
      send(3'd1, 8'd3, 8'd5, res(8'd254, 1, 0, 1, 0));
      send(3'd5, 8'h01, 8'h01, res(8'h03, 0, 0, 0, 0));
      // carry chain
      send(3'd0, 8'hFF, 8'h01, res(8'h00, 1, 1, 0, 0));
      send(3'd5, 8'h00, 8'h00, res(8'h01, 0, 0, 0, 0));
      send(3'd5, 8'h00, 8'h00, res(8'h00, 0, 1, 0, 0));
      // overflow, shifts, logic ops
      send(3'd0, 8'h7F, 8'h01, res(8'h80, 0, 0, 1, 1));
      send(3'd6, 8'h81, 8'd1, res(8'h02, 0, 0, 0, 0));
      send(3'd7, 8'h81, 8'd9, res(8'h40, 0, 0, 0, 0));
      send(3'd2, 8'hF0, 8'h3C, res(8'h30, 0, 0, 0, 0));
      send(3'd3, 8'hF0, 8'h0F, res(8'hFF, 0, 0, 1, 0));
      send(3'd4, 8'hAA, 8'hAA, res(8'h00, 0, 1, 0, 0));
      idle();
      repeat (3) step();

      // back-pressure: two accepts fill the pipe, third waits
      bus.out_ready = 1'b0;
      send(3'd0, 8'd1, 8'd1, res(8'd2, 0, 0, 0, 0));
      send(3'd0, 8'd2, 8'd2, res(8'd4, 0, 0, 0, 0));
      drive(3'd0, 8'd3, 8'd3, res(8'd6, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_y_hold", bus.y, 8'd2);
         step();
      end
      bus.out_ready = 1'b1;
      wait_accept("bp_accept_timeout");
      idle();
      repeat (4) step();

      // reset mid-stream with carry-producing ops in flight
      bus.out_ready = 1'b0;
      send(3'd0, 8'hFF, 8'hFF, res(8'hFE, 1, 0, 1, 0));
      send(3'd0, 8'h80, 8'h80, res(8'h00, 1, 1, 0, 1));
      idle();
      step();
      check("full_before_reset", {bus.out_valid, bus.in_ready}, 2'b10);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_y", bus.y, 0);
      step();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      check("rst_in_ready", bus.in_ready, 1);
      send(3'd5, 8'h00, 8'h00, res(8'h00, 0, 1, 0, 0));
      idle();

      // drain
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("drain_empty", exp_q.size(), 0);
      step();
      check("final_out_valid", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU that succeeds the fixed 8-bit combinational ALU. It has configurable operand width, eight operations, a carry-chain operation (ADC) and full signed/unsigned flags. It also has valid/ready handshakes on both sides, so it can sit between a register-file read stage and a writeback/FIFO stage with back-pressure. Throughput is one operation per cycle, latency is two cycles, and results are delivered strictly in order.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64; SW = $clog2(WIDTH) is the shift-amount width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operation presented on a/b/opcode
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shifts, only b[SW-1:0] is used
- opcode  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADC, 6 SLL, 7 SRL
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- y  out  WIDTH  result
- carryout  out  1  carry (ADD/ADC) or borrow (SUB); 0 for all other ops
- zero  out  1  y == 0
- negative  out  1  y[WIDTH-1]
- overflow  out  1  signed overflow (ADD/ADC/SUB); 0 for all other ops

## Operation
- Pipeline:
  - S1 registers a, b and opcode on input accept (in_valid && in_ready).
  - Execute logic is combinational from S1.
  - S2 registers y and the four flags. S2 drives the outputs directly.
- Stage advance rules:
  - S2 loads when S1 is valid and (S2 is empty or out_ready).
  - S1 loads when in_valid and (S1 is empty or S1 advances this cycle).
  - in_ready = !s1_valid || s1_advance. This is the registered-stall form; no combinational path from in_valid to in_ready.
- Arithmetic, with results computed to WIDTH+1 bits and the MSB giving carry/borrow:
  - ADD: {c,y} = a+b.
  - SUB: {c,y} = a−b, with c = 1 when a<b unsigned.
  - ADC: {c,y} = a+b+cf.
- Overflow:
  - ADD/ADC: (a[msb]==b[msb]) && (y[msb]!=a[msb]).
  - SUB: (a[msb]!=b[msb]) && (y[msb]!=a[msb]).
- Logic ops: AND, OR and XOR are bitwise.
- Shifts: SLL/SRL are logical shifts by b[SW-1:0], zero-filled.
- Flags for AND, OR, XOR, SLL and SRL: carryout = 0 and overflow = 0.
- zero and negative are computed from the final y for every opcode.
- cf is an internal carry register:
  - It updates to the new carryout every time an op moves S1→S2, including ops that write carryout = 0.
  - ADC therefore uses the carry of the immediately preceding op in program order, regardless of stalls.
- While out_valid && !out_ready, the S2 contents (y and all flags) hold stable. S1 holds as well if it is occupied.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - s1_valid, s2_valid, out_valid and cf to 0
  - y, carryout, zero, negative and overflow to 0
  - in_ready to 1 once rst_n is high
- Reset asserted mid-operation discards all in-flight ops; no partial result ever appears.
- Latency: an op accepted at edge N is presented with out_valid=1 after edge N+1 (S1 at N, S2 at N+1) when not stalled. Each stall cycle adds one cycle.
- Throughput: one op per cycle when out_ready is held at 1.
- Capacity: 2 ops. in_ready falls only when both S1 and S2 are full and out_ready=0.
- Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
- out_valid never drops without a handshake (out_valid && out_ready).

## Test plan
- Reset then ADD at WIDTH=8, a=200, b=100 -> y=44, carryout=1, zero=0, negative=0, overflow=0, out_valid two edges after accept.
- Two SUBs back-to-back:
  - a=5, b=5 -> y=0, zero=1, carryout=0.
  - a=3, b=5 -> y=254, carryout=1, negative=1, overflow=0.
- Carry chain, issued back-to-back with no idle cycles:
  - ADD 0xFF+0x01 -> y=0x00, carryout=1.
  - ADC 0x00+0x00 -> y=0x01, carryout=0.
  - ADC 0x00+0x00 -> y=0x00, zero=1.
- Signed overflow and shifts:
  - ADD 0x7F+0x01 -> y=0x80, overflow=1, negative=1, carryout=0.
  - SLL a=0x81, b=1 -> y=0x02, carryout=0.
  - SRL a=0x81, b=9 (shamt=1) -> y=0x40.
- Back-pressure: out_ready=0 for 5 cycles while in_valid=1 with ops ADD 1+1, ADD 2+2, ADD 3+3.
  - in_ready=0 after two accepts; y=2 is held stable.
  - After release, results 2, 4, 6 appear in order, with no loss or duplication.
- Reset mid-stream: rst_n low for 1 cycle while both stages are full -> out_valid=0 and cf=0 immediately. A following ADC 0+0 gives y=0.
